// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared types and shift helper for the multicycle ALU
package alu_mc_pkg;

    // Widest operand the shift helper handles; the ALU width must not exceed it.
    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_DIV   = 3'b010,
        OP_MUL   = 3'b011,
        OP_SHIFT = 3'b100,
        OP_REM   = 3'b101,
        OP_MOV   = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIN  = 2'b11
    } state_e;

    function automatic logic is_divop(input op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Shifts the low 'width' bits of val; bits above width are returned as zero.
    // amt is always below width, so ROR never needs an explicit modulo.
    function automatic logic [MAX_W-1:0] shift_fn(
        input logic [MAX_W-1:0] val,
        input logic [5:0]       amt,
        input shift_e           kind,
        input logic [6:0]       width
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] v;
        logic [MAX_W-1:0] r;
        logic [5:0]       msb;
        mask = (width >= 7'd64) ? {MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
        v    = val & mask;
        msb  = 6'(width - 7'd1);
        r    = v;
        case (kind)
            SH_LSL: r = (v << amt) & mask;
            SH_LSR: r = v >> amt;
            SH_ASR: begin
                r = v >> amt;
                if (v[msb]) begin
                    r = r | (mask & ~(mask >> amt));
                end
            end
            SH_ROR: begin
                if (amt != 6'd0) begin
                    r = ((v >> amt) | (v << (width - {1'b0, amt}))) & mask;
                end
            end
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/response bundle between execute control and the ALU
interface alu_multicycle_if #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2:0]     ALUControl;
    logic [SHW-1:0] Shamt;
    logic [1:0]     ShiftType;
    logic           busy;
    logic           done;
    logic [N-1:0]   Result;
    logic [3:0]     ALUFlags;
    logic           DivByZero;

    modport master (
        output start, a, b, ALUControl, Shamt, ShiftType,
        input  busy, done, Result, ALUFlags, DivByZero
    );

    modport slave (
        input  start, a, b, ALUControl, Shamt, ShiftType,
        output busy, done, Result, ALUFlags, DivByZero
    );
endinterface

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - shared shift-add multiply / restoring divide datapath
module iter_muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         mode,        // 0 = multiply, 1 = divide
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         step,
    output logic [N-1:0] product_lo,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    // acc: product accumulator (mul) or partial remainder (div, N+1 bits)
    // q:   multiplier shifting right (mul) or dividend/quotient shifting left (div)
    // d:   multiplicand shifting left (mul) or fixed divisor (div)
    logic [N:0]   acc_q, acc_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] d_q, d_d;

    logic [N-1:0] addend;
    logic [N-1:0] mul_sum;
    logic [N+1:0] shifted;
    logic [N+1:0] trial;
    logic         fits;
    logic [N:0]   div_acc;
    logic [N-1:0] div_q;

    // One iteration of each algorithm; outputs are the values after the current step,
    // so the parent can capture the final answer during the last step cycle.
    always_comb begin
        addend   = q_q[0] ? d_q : '0;
        mul_sum  = acc_q[N-1:0] + addend;
        shifted  = {acc_q, q_q[N-1]};
        trial    = shifted - {2'b00, d_q};
        fits     = ~trial[N+1];
        div_acc  = fits ? trial[N:0] : shifted[N:0];
        div_q    = {q_q[N-2:0], fits};

        product_lo = mul_sum;
        quotient   = div_q;
        remainder  = div_acc[N-1:0];

        acc_d = acc_q;
        q_d   = q_q;
        d_d   = d_q;
        if (load) begin
            acc_d = '0;
            q_d   = mode ? a : b;
            d_d   = mode ? b : a;
        end else if (step) begin
            if (mode) begin
                acc_d = div_acc;
                q_d   = div_q;
            end else begin
                acc_d = {1'b0, mul_sum};
                q_d   = q_q >> 1;
                d_d   = d_q << 1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            q_q   <= '0;
            d_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            d_q   <= d_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with start/busy/done and iterative mul/div
module alu_multicycle
    import alu_mc_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    alu_multicycle_if.slave bus
);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [N-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           dbz_q, dbz_d;

    op_e            op_in;
    logic [N:0]     sum;
    logic [N-1:0]   b_eff;
    logic [N-1:0]   sc_result;
    logic           sc_c;
    logic           sc_v;
    logic [MAX_W-1:0] sh_val;
    logic [5:0]     sh_amt;
    logic [N-1:0]   fin_res;

    logic           load;
    logic           step;
    logic           mode_div;
    logic [N-1:0]   product_lo;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;

    assign op_in = op_e'(bus.ALUControl);

    // Result and C/V for every op that completes in the accept cycle (incl. divide by zero)
    always_comb begin
        b_eff     = (op_in == OP_SUB) ? ~bus.b : bus.b;
        sum       = {1'b0, bus.a} + {1'b0, b_eff} + {{N{1'b0}}, (op_in == OP_SUB)};
        sh_val    = '0;
        sh_val[N-1:0] = bus.b;
        sh_amt    = '0;
        sh_amt[SHW-1:0] = bus.Shamt;
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (op_in)
            OP_ADD, OP_SUB: begin
                sc_result = sum[N-1:0];
                sc_c      = sum[N];
                sc_v      = (bus.a[N-1] == b_eff[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            OP_DIV:   sc_result = '1;
            OP_REM:   sc_result = bus.a;
            OP_SHIFT: sc_result = N'(shift_fn(sh_val, sh_amt, shift_e'(bus.ShiftType), 7'(N)));
            OP_MOV:   sc_result = bus.a;
            default:  sc_result = '0;
        endcase
    end

    // Control FSM: accept in IDLE, iterate N steps in MUL/DIV, publish in FIN
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        dbz_d    = dbz_q;
        load     = 1'b0;
        step     = 1'b0;
        fin_res  = '0;
        mode_div = (state_q == IDLE) ? is_divop(op_in) : (state_q == DIV);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load  = 1'b1;
                    op_d  = op_in;
                    dbz_d = is_divop(op_in) && (bus.b == '0);
                    if (op_in == OP_MUL) begin
                        state_d = MUL;
                        cnt_d   = SHW'(N - 1);
                    end else if (is_divop(op_in) && (bus.b != '0)) begin
                        state_d = DIV;
                        cnt_d   = SHW'(N - 1);
                    end else begin
                        state_d  = FIN;
                        result_d = sc_result;
                        flags_d  = {sc_result[N-1], (sc_result == '0), sc_c, sc_v};
                    end
                end
            end
            MUL, DIV: begin
                step  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = FIN;
                    cnt_d    = '0;
                    if (state_q == MUL) begin
                        fin_res = product_lo;
                    end else if (op_q == OP_REM) begin
                        fin_res = remainder;
                    end else begin
                        fin_res = quotient;
                    end
                    result_d = fin_res;
                    flags_d  = {fin_res[N-1], (fin_res == '0), 2'b00};
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            dbz_q    <= dbz_d;
        end
    end

    iter_muldiv #(.N(N)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .mode       (mode_div),
        .a          (bus.a),
        .b          (bus.b),
        .step       (step),
        .product_lo (product_lo),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    assign bus.busy      = (state_q == MUL) || (state_q == DIV);
    assign bus.done      = (state_q == FIN);
    assign bus.Result    = result_q;
    assign bus.ALUFlags  = flags_q;
    assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle
module tb_alu_multicycle;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_multicycle_if #(.N(32)) bus ();

    alu_multicycle #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour computed with plain integer arithmetic
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input logic [1:0] st,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output logic dz, output int lat);
        longint unsigned full;
        longint          s;
        logic            c;
        logic            v;
        c = 1'b0; v = 1'b0; dz = 1'b0; lat = 1; r = '0;
        case (op)
            3'd0: begin
                full = longint'(a) + longint'(b);
                r = a + b;
                c = (full > 64'hFFFF_FFFF);
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
                else begin r = a / b; lat = 33; end
            end
            3'd3: begin r = a * b; lat = 33; end
            3'd4: begin
                case (st)
                    2'd0: r = b << sh;
                    2'd1: r = b >> sh;
                    2'd2: r = $signed(b) >>> sh;
                    default: r = (sh == 0) ? b : ((b >> sh) | (b << (32 - sh)));
                endcase
            end
            3'd5: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else begin r = a % b; lat = 33; end
            end
            3'd6: r = a;
            default: r = '0;
        endcase
        f = {r[31], (r == 0), c, v};
    endfunction

    // Issue one request in the current (idle) cycle, wait for done, check, step one cycle on
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [1:0] st);
        logic [31:0] er;
        logic [3:0]  ef;
        logic        ez;
        int          el;
        int          lat;
        int          bcnt;
        model(op, a, b, sh, st, er, ef, ez, el);
        bus.start = 1'b1; bus.ALUControl = op; bus.a = a; bus.b = b;
        bus.Shamt = sh; bus.ShiftType = st;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1; bcnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(el));
        check_eq({tag, " busy_cycles"}, 64'(bcnt), 64'(el - 1));
        check_eq({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check_eq({tag, " result"}, 64'(bus.Result), 64'(er));
        check_eq({tag, " flags"}, 64'(bus.ALUFlags), 64'(ef));
        check_eq({tag, " divbyzero"}, 64'(bus.DivByZero), 64'(ez));
        @(posedge clk); #1;
        check_eq({tag, " done_low"}, 64'(bus.done), 64'd0);
        check_eq({tag, " result_held"}, 64'(bus.Result), 64'(er));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] mul_r;
    logic [3:0]  mul_f;
    logic        mul_z;
    int          mul_l;
    int          lat;

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ALUControl = '0;
        bus.Shamt = '0; bus.ShiftType = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy", 64'(bus.busy), 64'd0);
        check_eq("reset done", 64'(bus.done), 64'd0);
        check_eq("reset result", 64'(bus.Result), 64'd0);
        check_eq("reset flags", 64'(bus.ALUFlags), 64'd0);
        check_eq("reset dbz", 64'(bus.DivByZero), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 2'd0);
        run_op("sub_zero", 3'd1, 32'd5, 32'd5, 5'd0, 2'd0);
        run_op("mul", 3'd3, 32'h0001_0003, 32'h0002_0005, 5'd0, 2'd0);
        run_op("mul_wrap", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 2'd0);
        run_op("div", 3'd2, 32'd100, 32'd7, 5'd0, 2'd0);
        run_op("rem", 3'd5, 32'd100, 32'd7, 5'd0, 2'd0);
        run_op("div0", 3'd2, 32'd9, 32'd0, 5'd0, 2'd0);
        run_op("add_clr", 3'd0, 32'd1, 32'd2, 5'd0, 2'd0);
        run_op("rem0", 3'd5, 32'h1234_5678, 32'd0, 5'd0, 2'd0);
        run_op("lsl", 3'd4, 32'd0, 32'h8000_0001, 5'd1, 2'd0);
        run_op("lsr", 3'd4, 32'd0, 32'h8000_0001, 5'd1, 2'd1);
        run_op("asr", 3'd4, 32'd0, 32'h8000_0001, 5'd1, 2'd2);
        run_op("ror", 3'd4, 32'd0, 32'h8000_0001, 5'd1, 2'd3);
        run_op("sh0", 3'd4, 32'd0, 32'h8000_0001, 5'd0, 2'd3);
        run_op("ror31", 3'd4, 32'd0, 32'h8000_0001, 5'd31, 2'd3);
        run_op("rsvd", 3'd7, 32'hDEAD_BEEF, 32'h1, 5'd3, 2'd1);

        // start while busy must be ignored; start in FIN must not be accepted
        model(3'd3, 32'h0001_0003, 32'h0002_0005, 5'd0, 2'd0, mul_r, mul_f, mul_z, mul_l);
        bus.start = 1'b1; bus.ALUControl = 3'd3; bus.a = 32'h0001_0003; bus.b = 32'h0002_0005;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        repeat (9) begin @(posedge clk); #1; lat++; end
        bus.start = 1'b1; bus.ALUControl = 3'd0; bus.a = $urandom; bus.b = $urandom;
        @(posedge clk); #1; lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        check_eq("hs latency", 64'(lat), 64'(mul_l));
        check_eq("hs result", 64'(bus.Result), 64'(mul_r));
        check_eq("hs flags", 64'(bus.ALUFlags), 64'(mul_f));
        bus.start = 1'b1; bus.ALUControl = 3'd6; bus.a = 32'h5555; bus.b = 32'h0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            check_eq("fin_start busy", 64'(bus.busy), 64'd0);
            check_eq("fin_start done", 64'(bus.done), 64'd0);
            @(posedge clk); #1;
        end
        check_eq("fin_start result", 64'(bus.Result), 64'(mul_r));
        run_op("b2b_add1", 3'd0, 32'h10, 32'h20, 5'd0, 2'd0);
        run_op("b2b_add2", 3'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, 2'd0);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), pick(), pick(),
                   5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end

        // asynchronous reset in the middle of a divide
        bus.start = 1'b1; bus.ALUControl = 3'd2; bus.a = 32'hFFFF_0000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check_eq("arst busy", 64'(bus.busy), 64'd0);
        check_eq("arst done", 64'(bus.done), 64'd0);
        check_eq("arst result", 64'(bus.Result), 64'd0);
        check_eq("arst flags", 64'(bus.ALUFlags), 64'd0);
        check_eq("arst dbz", 64'(bus.DivByZero), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (25) begin
            check_eq("arst no_done", 64'(bus.done), 64'd0);
            @(posedge clk); #1;
        end
        run_op("mov_after_rst", 3'd6, 32'h1234, 32'h0, 5'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
